uart_rx: RTL and testbench

UART receiver and counterpart of the team's uart_tx. Frame format is 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), with the line idling high. Bit time matches the transmitter at 2604 clk cycles per bit. Received bytes go to a ready/clear handshake with framing-error and overrun flags, for use by the command-processing logic.

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a ready/clear byte handshake.
// Flags framing errors (stop bit low) and overruns (byte lost while rdy set).
module uart_rx #(
    parameter int unsigned BAUD_CNT = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_CNT - 1);
    localparam logic [11:0] HALF_LAST = 12'((BAUD_CNT / 2) - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        rx_m;
    logic        rx_s;
    logic        rx_s_prev;
    logic [2:0]  primed;
    logic [11:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shifter;
    logic        baud_clr;
    logic        bit_clr;
    logic        shift_en;
    logic        stop_good;
    logic        stop_bad;

    // Two-flop synchronizer plus history flop; primed blocks edge
    // detection until all three flops hold real line samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_prev <= 1'b1;
            primed    <= 3'b000;
        end else begin
            rx_m      <= RX;
            rx_s      <= rx_m;
            rx_s_prev <= rx_s;
            primed    <= {primed[1:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and per-cycle datapath controls.
    always_comb begin
        state_next = state;
        baud_clr   = 1'b0;
        bit_clr    = 1'b0;
        shift_en   = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        unique case (state)
            IDLE: begin
                baud_clr = 1'b1;
                bit_clr  = 1'b1;
                if (primed[2] && rx_s_prev && !rx_s)
                    state_next = START;
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_clr   = 1'b1;
                    bit_clr    = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_clr = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == 4'd7)
                        state_next = STOP;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_clr   = 1'b1;
                    stop_good  = rx_s;
                    stop_bad   = !rx_s;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Baud and bit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            baud_cnt <= baud_clr ? 12'd0 : baud_cnt + 12'd1;
            if (bit_clr)       bit_cnt <= 4'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // LSB-first shifter: sampled bit enters at the MSB.
    always_ff @(posedge clk) begin
        if (rst)           shifter <= '0;
        else if (shift_en) shifter <= {rx_s, shifter[7:1]};
    end

    // Output handshake; a completing good frame wins over clr_rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data <= '0;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            ovr     <= 1'b0;
        end else if (stop_good) begin
            rx_data <= shifter;
            rdy     <= 1'b1;
            frm_err <= 1'b0;
            ovr     <= rdy && !clr_rdy;
        end else begin
            if (stop_bad)
                frm_err <= 1'b1;
            if (clr_rdy) begin
                rdy <= 1'b0;
                ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, timed corner cases,
// and random frames against a per-frame reference model.
module tb_uart_rx;

    localparam int B    = 32;
    localparam int HALF = B / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr;

    int checks = 0;
    int errors = 0;
    int lat;

    uart_rx #(.BAUD_CNT(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       b2b;
        logic       clr;
        logic [7:0] e_data;
        logic       e_rdy;
        logic       e_frm;
        logic       e_ovr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d,
                             input logic r, input logic f, input logic o);
        check({tag, ".rx_data"}, {24'd0, rx_data}, {24'd0, d});
        check({tag, ".rdy"}, {31'd0, rdy}, {31'd0, r});
        check({tag, ".frm_err"}, {31'd0, frm_err}, {31'd0, f});
        check({tag, ".ovr"}, {31'd0, ovr}, {31'd0, o});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        RX = b;
        idle(B);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        RX = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        idle(1);
        clr_rdy = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m_data;
        logic       m_rdy;
        logic       m_frm;
        logic       m_ovr;
        logic [7:0] d;
        logic       good;
        int         gap;
        int         lo;
        int         hi;

        vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hAA, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};

        rst     = 1'b1;
        RX      = 1'b1;
        clr_rdy = 1'b0;
        idle(3);
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(8);

        // First frame with latency measured from the pin falling.
        lat = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while (!rdy && lat < 2000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        lo = HALF + 9 * B + 2;
        hi = HALF + 9 * B + 6;
        checks++;
        if (lat < lo || lat > hi) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d..%0d", lat, lo, hi);
        end
        check_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        pulse_clr();
        check_out("a5_clr", 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Directed frame table.
        for (int i = 0; i < 4; i++) begin
            if (!vecs[i].b2b) idle(4);
            send_byte(vecs[i].data, vecs[i].stop);
            check_out($sformatf("vec%0d", i), vecs[i].e_data,
                      vecs[i].e_rdy, vecs[i].e_frm, vecs[i].e_ovr);
            if (vecs[i].clr) begin
                pulse_clr();
                check_out($sformatf("vec%0d_clr", i), vecs[i].e_data,
                          1'b0, vecs[i].e_frm, 1'b0);
            end
        end

        // Short low glitch must not start a frame.
        idle(4);
        RX = 1'b0;
        idle(6);
        RX = 1'b1;
        idle(12 * B);
        check_out("glitch", 8'hAA, 1'b0, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b1);
        check_out("after_glitch", 8'h3C, 1'b1, 1'b0, 1'b0);

        // clr_rdy in the exact stop-sample cycle with rdy already set.
        idle(4);
        fork
            send_byte(8'h0F, 1'b1);
            begin
                repeat (2 + HALF + 9 * B) @(posedge clk);
                #1 clr_rdy = 1'b1;
                @(posedge clk);
                #1 clr_rdy = 1'b0;
            end
        join
        check_out("collide", 8'h0F, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of data bit 4 of 0xFF.
        idle(4);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        RX = 1'b1;
        idle(HALF);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(12 * B);
        check_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        idle(4);
        send_byte(8'h12, 1'b1);
        check_out("after_reset", 8'h12, 1'b1, 1'b0, 1'b0);

        // Random frames against the per-frame model.
        m_data = 8'h12;
        m_rdy  = 1'b1;
        m_frm  = 1'b0;
        m_ovr  = 1'b0;
        good   = 1'b1;
        for (int i = 0; i < 60; i++) begin
            gap = good ? $urandom_range(0, 3) : $urandom_range(4, 8);
            if (gap > 0) idle(gap);
            d    = 8'($urandom);
            good = ($urandom_range(0, 9) != 0);
            send_byte(d, good);
            if (good) begin
                m_ovr  = m_rdy;
                m_rdy  = 1'b1;
                m_data = d;
                m_frm  = 1'b0;
            end else begin
                m_frm = 1'b1;
            end
            check_out($sformatf("rnd%0d", i), m_data, m_rdy, m_frm, m_ovr);
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
                m_rdy = 1'b0;
                m_ovr = 1'b0;
                check_out($sformatf("rnd%0d_clr", i), m_data, m_rdy,
                          m_frm, m_ovr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
